mem_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the 8x32 word memory.
- Serialises read/write transactions from two masters (port A, port B) onto the single memory port (addr, datai, we, read, datao).
- Registers read data and returns a one-cycle acknowledge.
- Sits between the control FSM(s) and the memory, replacing direct memory hookup.

---
 rtl/mem_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter that serialises read/write transactions onto a single
// word-memory port, registering read data and returning a one-cycle acknowledge.
module mem_rr_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_i,
  input  logic              a_wr_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_ack_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_wr_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_datai_o,
  output logic              mem_we_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_datao_i,
  output logic              busy_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StAck    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = port B
  logic              winner_q, winner_d;          // 1 = port B
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_datai_q, mem_datai_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_read_q, mem_read_d;
  logic              busy_q, busy_d;

  logic grant_b;
  logic sel_wr;

  // B wins when alone, or on a tie when A was served last.
  assign grant_b = b_req_i & (~a_req_i | ~last_grant_q);
  assign sel_wr  = grant_b ? b_wr_i : a_wr_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_datai_d  = mem_datai_q;
    mem_we_d     = mem_we_q;
    mem_read_d   = mem_read_q;
    busy_d       = busy_q;

    case (state_q)
      StIdle: begin
        if (a_req_i || b_req_i) begin
          state_d      = StAccess;
          winner_d     = grant_b;
          last_grant_d = grant_b;
          busy_d       = 1'b1;
          mem_addr_d   = grant_b ? b_addr_i : a_addr_i;
          mem_datai_d  = grant_b ? b_wdata_i : a_wdata_i;
          mem_we_d     = sel_wr;
          mem_read_d   = ~sel_wr;
        end
      end
      StAccess: begin
        state_d = StAck;
        if (mem_read_q) begin
          if (winner_q) begin
            b_rdata_d = mem_datao_i;
          end else begin
            a_rdata_d = mem_datao_i;
          end
        end
        a_ack_d     = ~winner_q;
        b_ack_d     = winner_q;
        mem_addr_d  = '0;
        mem_datai_d = '0;
        mem_we_d    = 1'b0;
        mem_read_d  = 1'b0;
      end
      StAck: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = StIdle;
        busy_d      = 1'b0;
        mem_addr_d  = '0;
        mem_datai_d = '0;
        mem_we_d    = 1'b0;
        mem_read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_datai_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_datai_q  <= mem_datai_d;
      mem_we_q     <= mem_we_d;
      mem_read_q   <= mem_read_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_datai_o = mem_datai_q;
  assign mem_we_o    = mem_we_q;
  assign mem_read_o  = mem_read_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of round-robin service and a shadow memory.
module tb_mem_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr, b_req, b_wr;
  logic [2:0]  a_addr, b_addr, mem_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_datai, mem_datao;
  logic        a_ack, b_ack, mem_we, mem_read, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int contention = 0;

  logic [31:0] mem [8] = '{default: 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_datai;
  assign mem_datao = mem_read ? mem[mem_addr] : 32'hBAD0_BAD0;

  always @(negedge clk) if (mem_we && mem_read) contention++;

  mem_rr_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .mem_addr_o(mem_addr), .mem_datai_o(mem_datai), .mem_we_o(mem_we),
    .mem_read_o(mem_read), .mem_datao_i(mem_datao), .busy_o(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Two reset edges; returns at a negedge with the DUT idle and rst released.
  task automatic do_reset();
    rst = 1'b1;
    a_req = 0; b_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one transaction from an idle negedge; returns at the ack negedge (req dropped).
  task automatic run_txn(input bit port, input bit wr, input logic [2:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata, output bit ok);
    ok = 0;
    rdata = '0;
    if (port) begin b_req = 1; b_wr = wr; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_wr = wr; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) begin
        ok = 1;
        rdata = port ? b_rdata : a_rdata;
      end
    end
    if (port) b_req = 0; else a_req = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_datai, mem_we, mem_read, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a_ack=%b b_ack=%b a_rdata=%h b_rdata=%h addr=%h datai=%h we=%b rd=%b busy=%b, required all 0",
               a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_datai, mem_we, mem_read, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_a_write();
    a_req = 1; a_wr = 1; a_addr = 3; a_wdata = 32'hDEADBEEF;
    n_tests++;
    if (mem_we !== 0 || busy !== 0) begin
      n_fail++; $display("FAIL wr_idle: we=%b busy=%b, required 0 0", mem_we, busy);
    end
    @(negedge clk);
    n_tests++;
    if ({mem_we, mem_read, mem_addr, mem_datai, busy, a_ack} !== {1'b1, 1'b0, 3'd3, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_access: we=%b rd=%b addr=%0d datai=%h busy=%b ack=%b, required 1 0 3 deadbeef 1 0",
               mem_we, mem_read, mem_addr, mem_datai, busy, a_ack);
    end
    @(negedge clk);
    n_tests++;
    if ({a_ack, b_ack, mem_we, mem_read, busy} !== 5'b10001) begin
      n_fail++;
      $display("FAIL wr_ack: a_ack=%b b_ack=%b we=%b rd=%b busy=%b, required 1 0 0 0 1",
               a_ack, b_ack, mem_we, mem_read, busy);
    end
    a_req = 0;
    @(negedge clk);
    n_tests++;
    if ({a_ack, b_ack, busy} !== 3'b000) begin
      n_fail++; $display("FAIL wr_done: a_ack=%b b_ack=%b busy=%b, required 0 0 0", a_ack, b_ack, busy);
    end
  endtask

  task automatic test_a_read();
    a_req = 1; a_wr = 0; a_addr = 3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (mem_we !== 0) begin n_fail++; $display("FAIL rd_we cycle %0d: we=%b, required 0", k, mem_we); end
      if (k == 1) begin
        n_tests++;
        if (mem_read !== 1 || mem_addr !== 3) begin
          n_fail++; $display("FAIL rd_access: rd=%b addr=%0d, required 1 3", mem_read, mem_addr);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (a_ack !== 1 || a_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rd_ack: ack=%b rdata=%h, required 1 deadbeef", a_ack, a_rdata);
        end
        a_req = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    int a_at, b_at;
    logic [31:0] rd;
    bit ok;
    do_reset();
    a_at = -1; b_at = -1;
    a_req = 1; a_wr = 1; a_addr = 1; a_wdata = 32'h11;
    b_req = 1; b_wr = 1; b_addr = 2; b_wdata = 32'h22;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_ack) begin a_at = k; a_req = 0; end
      if (b_ack) begin b_at = k; b_req = 0; end
    end
    n_tests++;
    if (a_at != 2 || b_at != 5) begin
      n_fail++; $display("FAIL sim_order: a_ack@%0d b_ack@%0d, required 2 5", a_at, b_at);
    end
    run_txn(0, 0, 1, 0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h11) begin n_fail++; $display("FAIL sim_rd_a: ok=%b rdata=%h, required 1 11", ok, rd); end
    run_txn(1, 0, 2, 0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h22) begin n_fail++; $display("FAIL sim_rd_b: ok=%b rdata=%h, required 1 22", ok, rd); end
  endtask

  task automatic test_contention();
    int cyc [8];
    bit prt [8];
    int n;
    n = 0;
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 1;
    b_req = 1; b_wr = 0; b_addr = 2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (a_ack && n < 8) begin
        cyc[n] = k; prt[n] = 0; n++;
        n_tests++;
        if (a_rdata !== 32'h11) begin n_fail++; $display("FAIL cont_rd_a: %h, required 11", a_rdata); end
      end
      if (b_ack && n < 8) begin
        cyc[n] = k; prt[n] = 1; n++;
        n_tests++;
        if (b_rdata !== 32'h22) begin n_fail++; $display("FAIL cont_rd_b: %h, required 22", b_rdata); end
      end
    end
    a_req = 0; b_req = 0;
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL cont_count: %0d acks, required 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      n_tests++;
      if (cyc[i] != 2 + 3 * i || prt[i] != bit'(i % 2)) begin
        n_fail++;
        $display("FAIL cont_ack%0d: cycle %0d port %0d, required cycle %0d port %0d",
                 i, cyc[i], prt[i], 2 + 3 * i, i % 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_access();
    b_req = 1; b_wr = 1; b_addr = 5; b_wdata = 32'h55;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1 || mem_addr !== 5) begin
      n_fail++; $display("FAIL rst_acc_access: we=%b addr=%0d, required 1 5", mem_we, mem_addr);
    end
    rst = 1; b_req = 0;
    @(negedge clk);
    n_tests++;
    if ({a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_datai, mem_we, mem_read, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_acc_outputs: b_ack=%b we=%b rd=%b busy=%b addr=%h datai=%h b_rdata=%h, required all 0",
               b_ack, mem_we, mem_read, busy, mem_addr, mem_datai, b_rdata);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({b_ack, busy, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL rst_acc_after: b_ack=%b busy=%b we=%b, required 0 0 0", b_ack, busy, mem_we);
    end
  endtask

  task automatic test_retention();
    logic [31:0] rd;
    bit ok;
    run_txn(1, 1, 2, 32'h22, rd, ok);
    run_txn(1, 0, 2, 0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h22) begin n_fail++; $display("FAIL ret_rd1: ok=%b rdata=%h, required 1 22", ok, rd); end
    run_txn(1, 1, 2, 32'h99, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h22) begin n_fail++; $display("FAIL ret_wr_ack: ok=%b rdata=%h, required 1 22", ok, rd); end
    run_txn(1, 0, 2, 0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h99) begin n_fail++; $display("FAIL ret_rd2: ok=%b rdata=%h, required 1 99", ok, rd); end
  endtask

  // Model: whenever the arbiter is free and some request is waiting, pick a winner by the
  // round-robin rule; its ack lands 2 cycles later and the arbiter is free again after 3.
  task automatic test_random();
    logic [31:0] shadow [8];
    bit          pend [2], chosen [2], p_wr [2];
    logic [2:0]  p_addr [2];
    logic [31:0] p_data [2], exp_rd [2], last_rd [2];
    int          exp_ack [2];
    int          free_at, w;
    bit          last, exp_a, obs;
    do_reset();
    for (int i = 0; i < 8; i++) shadow[i] = mem[i];
    last = 1; free_at = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; chosen[p] = 0; last_rd[p] = '0; exp_ack[p] = -1;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        exp_a = pend[p] && chosen[p] && exp_ack[p] == c;
        obs = (p == 1) ? b_ack : a_ack;
        n_tests++;
        if (obs !== exp_a) begin
          n_fail++; $display("FAIL rnd_ack port %0d cycle %0d: %b, required %b", p, c, obs, exp_a);
        end
        if (exp_a) begin
          n_tests++;
          if (((p == 1) ? b_rdata : a_rdata) !== exp_rd[p]) begin
            n_fail++;
            $display("FAIL rnd_rdata port %0d cycle %0d: %h, required %h",
                     p, c, (p == 1) ? b_rdata : a_rdata, exp_rd[p]);
          end
          pend[p] = 0; chosen[p] = 0;
          if (p == 1) b_req = 0; else a_req = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          pend[p] = 1;
          p_wr[p] = 1'($urandom_range(1, 0));
          p_addr[p] = 3'($urandom_range(7, 0));
          p_data[p] = $urandom;
          if (p == 1) begin b_req = 1; b_wr = p_wr[p]; b_addr = p_addr[p]; b_wdata = p_data[p]; end
          else        begin a_req = 1; a_wr = p_wr[p]; a_addr = p_addr[p]; a_wdata = p_data[p]; end
        end
      end
      if (c >= free_at && ((pend[0] && !chosen[0]) || (pend[1] && !chosen[1]))) begin
        if (pend[0] && !chosen[0] && pend[1] && !chosen[1]) w = last ? 0 : 1;
        else w = (pend[1] && !chosen[1]) ? 1 : 0;
        chosen[w] = 1; exp_ack[w] = c + 2; free_at = c + 3; last = bit'(w);
        if (p_wr[w]) begin
          exp_rd[w] = last_rd[w];
          shadow[p_addr[w]] = p_data[w];
        end else begin
          exp_rd[w] = shadow[p_addr[w]];
          last_rd[w] = exp_rd[w];
        end
      end
      @(negedge clk);
    end
    a_req = 0; b_req = 0;
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_a_read();
    test_simultaneous();
    test_contention();
    test_reset_access();
    test_retention();
    test_random();
    n_tests++;
    if (contention != 0) begin
      n_fail++; $display("FAIL bus_contention: %0d cycles with we and read high, required 0", contention);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
